m_cp0: RTL and testbench
========================

// Module: m_cp0
// PURPOSE
//  Coprocessor-0 for the 5-stage MIPS core, in the M stage beside DM. Holds SR/Cause/EPC, executes mtc0/mfc0/eret.
//  Arbitrates interrupts and exceptions into one request. Drives M_CP0_Rdata into the M-stage GRF write-data select.
//  Req flushes the pipeline and redirects fetch to 0x0000_4180; EPC_out feeds eret.
// PARAMETERS
//  PRID_VALUE  32'h0000_7A7A  constant read from CP0 reg 15 (only with CP0_PRID_EN)
//  HANDLER_PC  32'h0000_4180  handler entry; only drives Handler_PC output
// PORTS
//  clk          in   1   system clock; all state updates on posedge
//  reset        in   1   synchronous, active-low (0 = reset), sampled on posedge clk
//  CP0_A        in   5   CP0 register number for mfc0 read and mtc0 write (rd field)
//  CP0_WD       in   32  mtc0 write data (forwarded rt value)
//  CP0_WE       in   1   mtc0 in M stage
//  M_PC         in   32  PC of the M-stage instruction
//  M_BD         in   1   M-stage instruction sits in a branch delay slot
//  M_ExcCode    in   5   exception code collected along the pipe; 0 = none
//  M_eret       in   1   eret in M stage; clears EXL
//  HWInt        in   6   external interrupt lines (timer0, timer1, interrupt generator, ...)
//  M_CP0_Rdata  out  32  combinational read of reg CP0_A
//  EPC_out      out  32  current EPC, same-cycle bypass of an mtc0 EPC write
//  Req          out  1   take exception/interrupt this cycle
//  Handler_PC   out  32  = HANDLER_PC
// BEHAVIOUR
//  Registers: SR(12) = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}.
//  Cause(13) = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}. EPC(14) = 32 bits, low 2 bits forced 0.
//  Reset (reset=0 at posedge): SR, Cause, EPC = 0. Req = 0 combinationally, since EXL=0 and IM=0.
//  IntReq = |(HWInt & IM) & IE & ~EXL. ExcReq = (M_ExcCode != 0) & ~EXL. Req = IntReq | ExcReq. Req is combinational, zero latency.
//  Interrupt has priority over exception.
//  On Req at posedge:
//   - EXL <= 1; Cause.BD <= M_BD.
//   - Cause.ExcCode <= IntReq ? 5'd0 : M_ExcCode.
//   - EPC <= M_BD ? M_PC-4 : M_PC, word-aligned.
//  IP <= HWInt every cycle, unconditionally (including the Req cycle).
//  mtc0 (CP0_WE & ~Req):
//   - reg 12 writes IM, EXL, IE.
//   - reg 14 writes EPC.
//   - reg 13 writes nothing (Cause is read-only to software).
//   - Other numbers are ignored.
//  Simultaneous Req and CP0_WE: Req wins and the write is dropped; the instruction re-executes after eret.
//  M_eret & ~Req: EXL <= 0 at the next posedge. eret never raises ExcCode itself.
//  EPC_out = (CP0_WE & ~Req & CP0_A==14) ? {CP0_WD[31:2],2'b0} : EPC, giving mtc0→eret back-to-back without a stall.
//  Reads: regs 12/13/14 return their values. All other numbers return 0. A read does not see a same-cycle write.
//  Reset mid-handler: all state returns to 0 and EXL drops; no pending Req survives.
//  M_ExcCode nonzero while EXL=1: Req stays 0 and no state changes.
// CONFIGURATION
//  CP0_PRID_EN defined: reg 15 reads PRID_VALUE; writes to it are ignored.
//  CP0_PRID_EN undefined: reg 15 reads 0 like any unimplemented register; no PRID logic is synthesised.
// STRUCTURE
//  cp0_pkg: register numbers (SR=12, CAUSE=13, EPC=14, PRID=15); ExcCode constants (Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12); field bit positions.
//  One sub-module, cp0_req_arbiter: combinational IntReq/ExcReq/Req and next ExcCode select.
//  Register file and read mux stay in m_cp0.
// TESTING
//  1 reset=0 two cycles, then mfc0 reg 12/13/14 -> all read 0, Req=0, EPC_out=0.
//  2 mtc0 SR=32'h0000_0401 (IM[10], IE); HWInt=6'b000001, M_PC=32'h3010, M_BD=0 -> Req=1 same cycle; next cycle EPC=32'h3010, Cause.ExcCode=0, EXL=1, Req=0.
//  3 EXL=0, IE=0, M_ExcCode=5'd12, M_BD=1, M_PC=32'h3024 -> Req=1; EPC=32'h3020, Cause=32'h8000_0030.
//  4 Req and mtc0 SR=0 in the same cycle -> SR keeps IM/IE and sets EXL; write dropped.
//  5 mtc0 EPC=32'h3047 with M_eret=0 -> EPC_out=32'h3044 that cycle; next cycle M_eret=1 -> EXL cleared.
//  6 EXL=1, HWInt all ones, M_ExcCode=5'd10 -> Req=0 and no register change; reset=0 mid-handler -> EXL=0 next posedge.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants for the M-stage coprocessor 0: register numbers, exception codes, field positions.
package cp0_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned EXC_W   = 5;
   localparam int unsigned HWINT_W = 6;

   localparam logic [ADDR_W-1:0] REG_SR    = 5'd12;
   localparam logic [ADDR_W-1:0] REG_CAUSE = 5'd13;
   localparam logic [ADDR_W-1:0] REG_EPC   = 5'd14;
   localparam logic [ADDR_W-1:0] REG_PRID  = 5'd15;

   localparam logic [EXC_W-1:0] EXC_INT     = 5'd0;
   localparam logic [EXC_W-1:0] EXC_ADEL    = 5'd4;
   localparam logic [EXC_W-1:0] EXC_ADES    = 5'd5;
   localparam logic [EXC_W-1:0] EXC_SYSCALL = 5'd8;
   localparam logic [EXC_W-1:0] EXC_RI      = 5'd10;
   localparam logic [EXC_W-1:0] EXC_OV      = 5'd12;

   localparam int unsigned SR_IE_BIT    = 0;
   localparam int unsigned SR_EXL_BIT   = 1;
   localparam int unsigned IM_LO        = 10;
   localparam int unsigned IM_HI        = 15;
   localparam int unsigned CAUSE_EXC_LO = 2;
   localparam int unsigned CAUSE_BD_BIT = 31;

   localparam logic [DATA_W-1:0] PRID_VALUE     = 32'h0000_7A7A;
   localparam logic [DATA_W-1:0] HANDLER_PC_DEF = 32'h0000_4180;

   // Return address for the faulting instruction: back up to the branch when in a delay slot.
   function automatic logic [DATA_W-1:0] epc_target(input logic [DATA_W-1:0] pc, input logic bd);
      logic [DATA_W-1:0] t;
      t = bd ? (pc - 32'd4) : pc;
      return {t[DATA_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/cp0_if.sv
// M-stage pipeline <-> CP0 signal bundle.
interface cp0_if;

   logic [cp0_pkg::ADDR_W-1:0]  CP0_A;
   logic [cp0_pkg::DATA_W-1:0]  CP0_WD;
   logic                        CP0_WE;
   logic [cp0_pkg::DATA_W-1:0]  M_PC;
   logic                        M_BD;
   logic [cp0_pkg::EXC_W-1:0]   M_ExcCode;
   logic                        M_eret;
   logic [cp0_pkg::HWINT_W-1:0] HWInt;
   logic [cp0_pkg::DATA_W-1:0]  M_CP0_Rdata;
   logic [cp0_pkg::DATA_W-1:0]  EPC_out;
   logic                        Req;
   logic [cp0_pkg::DATA_W-1:0]  Handler_PC;

   modport master (
      output CP0_A, CP0_WD, CP0_WE, M_PC, M_BD, M_ExcCode, M_eret, HWInt,
      input  M_CP0_Rdata, EPC_out, Req, Handler_PC
   );

   modport slave (
      input  CP0_A, CP0_WD, CP0_WE, M_PC, M_BD, M_ExcCode, M_eret, HWInt,
      output M_CP0_Rdata, EPC_out, Req, Handler_PC
   );

endinterface

// File: rtl/cp0_req_arbiter.sv
// Combines masked interrupts and pipeline exceptions into one request; interrupts win.
module cp0_req_arbiter
   import cp0_pkg::*;
(
   input  logic [HWINT_W-1:0] hwint_i,
   input  logic [HWINT_W-1:0] im_i,
   input  logic               ie_i,
   input  logic               exl_i,
   input  logic [EXC_W-1:0]   exc_code_i,
   output logic               req_o,
   output logic [EXC_W-1:0]   exc_code_nxt_o
);

   logic int_req;
   logic exc_req;

   always_comb begin
      int_req        = (|(hwint_i & im_i)) & ie_i & ~exl_i;
      exc_req        = (exc_code_i != '0) & ~exl_i;
      req_o          = int_req | exc_req;
      exc_code_nxt_o = int_req ? EXC_INT : exc_code_i;
   end

endmodule

// File: rtl/m_cp0.sv
// Coprocessor 0 (SR/Cause/EPC, mtc0/mfc0/eret, exception request) for the M stage.
// Optional feature: define CP0_PRID_EN to make register 15 read the processor ID.
module m_cp0
   import cp0_pkg::*;
#(
   parameter logic [DATA_W-1:0] HANDLER_PC = HANDLER_PC_DEF
) (
   input  logic  clk,
   input  logic  reset,
   cp0_if.slave  bus
);

   logic [HWINT_W-1:0] im_q;
   logic               exl_q;
   logic               ie_q;
   logic               bd_q;
   logic [HWINT_W-1:0] ip_q;
   logic [EXC_W-1:0]   exc_code_q;
   logic [DATA_W-1:2]  epc_q;

   logic               req;
   logic [EXC_W-1:0]   exc_code_nxt;
   logic               wr_sr;
   logic               wr_epc;
   logic [DATA_W-1:0]  epc_nxt;

   cp0_req_arbiter u_arb (
      .hwint_i        (bus.HWInt),
      .im_i           (im_q),
      .ie_i           (ie_q),
      .exl_i          (exl_q),
      .exc_code_i     (bus.M_ExcCode),
      .req_o          (req),
      .exc_code_nxt_o (exc_code_nxt)
   );

   // A request squashes the M-stage mtc0; it re-executes after eret.
   always_comb begin
      wr_sr   = bus.CP0_WE & ~req & (bus.CP0_A == REG_SR);
      wr_epc  = bus.CP0_WE & ~req & (bus.CP0_A == REG_EPC);
      epc_nxt = epc_target(bus.M_PC, bus.M_BD);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ip_q       <= '0;
         exc_code_q <= '0;
         epc_q      <= '0;
      end else begin
         ip_q <= bus.HWInt;
         if (req) begin
            exl_q      <= 1'b1;
            bd_q       <= bus.M_BD;
            exc_code_q <= exc_code_nxt;
            epc_q      <= epc_nxt[DATA_W-1:2];
         end else begin
            if (wr_sr) begin
               im_q  <= bus.CP0_WD[IM_HI:IM_LO];
               exl_q <= bus.CP0_WD[SR_EXL_BIT];
               ie_q  <= bus.CP0_WD[SR_IE_BIT];
            end
            if (wr_epc) begin
               epc_q <= bus.CP0_WD[DATA_W-1:2];
            end
            if (bus.M_eret) begin
               exl_q <= 1'b0;
            end
         end
      end
   end

   // mfc0 read mux; reads return pre-write state.
   always_comb begin
      bus.M_CP0_Rdata = '0;
      case (bus.CP0_A)
         REG_SR:    bus.M_CP0_Rdata = {16'b0, im_q, 8'b0, exl_q, ie_q};
         REG_CAUSE: bus.M_CP0_Rdata = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
         REG_EPC:   bus.M_CP0_Rdata = {epc_q, 2'b00};
`ifdef CP0_PRID_EN
         REG_PRID:  bus.M_CP0_Rdata = PRID_VALUE;
`endif
         default:   bus.M_CP0_Rdata = '0;
      endcase
   end

   // EPC bypass lets eret directly follow an mtc0 to EPC.
   always_comb begin
      bus.EPC_out    = wr_epc ? {bus.CP0_WD[DATA_W-1:2], 2'b00} : {epc_q, 2'b00};
      bus.Req        = req;
      bus.Handler_PC = HANDLER_PC;
   end

endmodule

// File: tb/tb_m_cp0.sv
// Directed cycle-by-cycle vector bench for m_cp0.
module tb_m_cp0;
   import cp0_pkg::*;

   typedef struct {
      logic        rst_n;
      logic [4:0]  a;
      logic [31:0] wd;
      logic        we;
      logic [31:0] pc;
      logic        bd;
      logic [4:0]  exc;
      logic        eret;
      logic [5:0]  hwint;
      logic        exp_req;
      logic [31:0] exp_rd;
      logic [31:0] exp_epc;
   } vec_t;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   vec_t vecs[$];

   cp0_if bus ();

   m_cp0 u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef CP0_PRID_EN
   localparam logic [31:0] EXP_PRID = 32'h0000_7A7A;
`else
   localparam logic [31:0] EXP_PRID = 32'h0;
`endif

   function automatic vec_t mk(input logic rst_n, input logic [4:0] a, input logic [31:0] wd,
                               input logic we, input logic [31:0] pc, input logic bd,
                               input logic [4:0] exc, input logic eret, input logic [5:0] hwint,
                               input logic exp_req, input logic [31:0] exp_rd,
                               input logic [31:0] exp_epc);
      vec_t v;
      v.rst_n = rst_n; v.a = a; v.wd = wd; v.we = we; v.pc = pc; v.bd = bd;
      v.exc = exc; v.eret = eret; v.hwint = hwint;
      v.exp_req = exp_req; v.exp_rd = exp_rd; v.exp_epc = exp_epc;
      return v;
   endfunction

   task automatic check32(input string name, input int idx, input logic [31:0] act,
                          input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reset         = v.rst_n;
      bus.CP0_A     = v.a;
      bus.CP0_WD    = v.wd;
      bus.CP0_WE    = v.we;
      bus.M_PC      = v.pc;
      bus.M_BD      = v.bd;
      bus.M_ExcCode = v.exc;
      bus.M_eret    = v.eret;
      bus.HWInt     = v.hwint;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;

      // reset and clean reads
      vecs.push_back(mk(1, 12, 0, 0, 0, 0, 0, 0, 6'h00, 0, 32'h0, 32'h0));
      vecs.push_back(mk(1, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0, 32'h0, 32'h0));
      vecs.push_back(mk(1, 14, 0, 0, 0, 0, 0, 0, 6'h00, 0, 32'h0, 32'h0));
      // mtc0 SR=0x401, then timer interrupt at 0x3010
      vecs.push_back(mk(1, 12, 32'h401, 1, 0, 0, 0, 0, 6'h00, 0, 32'h0, 32'h0));
      vecs.push_back(mk(1, 12, 0, 0, 32'h3010, 0, 0, 0, 6'h01, 1, 32'h401, 32'h0));
      vecs.push_back(mk(1, 14, 0, 0, 0, 0, 0, 0, 6'h01, 0, 32'h3010, 32'h3010));
      vecs.push_back(mk(1, 13, 0, 0, 0, 0, 0, 0, 6'h01, 0, 32'h400, 32'h3010));
      vecs.push_back(mk(1, 12, 0, 0, 0, 0, 0, 0, 6'h00, 0, 32'h403, 32'h3010));
      // mtc0 EPC=0x3047 bypass, then eret
      vecs.push_back(mk(1, 14, 32'h3047, 1, 0, 0, 0, 0, 6'h00, 0, 32'h3010, 32'h3044));
      vecs.push_back(mk(1, 12, 0, 0, 0, 0, 0, 1, 6'h00, 0, 32'h403, 32'h3044));
      vecs.push_back(mk(1, 12, 0, 0, 0, 0, 0, 0, 6'h00, 0, 32'h401, 32'h3044));
      // IE=0, overflow in delay slot at 0x3024
      vecs.push_back(mk(1, 12, 32'h0, 1, 0, 0, 0, 0, 6'h00, 0, 32'h401, 32'h3044));
      vecs.push_back(mk(1, 13, 0, 0, 32'h3024, 1, 5'd12, 0, 6'h00, 1, 32'h0, 32'h3044));
      vecs.push_back(mk(1, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0, 32'h8000_0030, 32'h3020));
      vecs.push_back(mk(1, 12, 0, 0, 0, 0, 0, 0, 6'h00, 0, 32'h2, 32'h3020));
      // EXL=1 masks everything
      vecs.push_back(mk(1, 13, 0, 0, 32'h5000, 0, 5'd10, 0, 6'h3F, 0, 32'h8000_0030, 32'h3020));
      vecs.push_back(mk(1, 14, 0, 0, 32'h5000, 0, 5'd10, 0, 6'h3F, 0, 32'h3020, 32'h3020));
      vecs.push_back(mk(1, 13, 0, 0, 32'h5000, 0, 5'd10, 0, 6'h3F, 0, 32'h8000_FC30, 32'h3020));
      // reset mid-handler
      vecs.push_back(mk(0, 12, 0, 0, 32'h5000, 0, 5'd10, 0, 6'h3F, 0, 32'h2, 32'h3020));
      vecs.push_back(mk(1, 12, 0, 0, 0, 0, 0, 0, 6'h00, 0, 32'h0, 32'h0));
      vecs.push_back(mk(1, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0, 32'h0, 32'h0));
      // Req and mtc0 SR=0 in the same cycle: write dropped
      vecs.push_back(mk(1, 12, 32'hFC01, 1, 0, 0, 0, 0, 6'h00, 0, 32'h0, 32'h0));
      vecs.push_back(mk(1, 12, 32'h0, 1, 32'h3100, 0, 0, 0, 6'h02, 1, 32'hFC01, 32'h0));
      vecs.push_back(mk(1, 12, 0, 0, 0, 0, 0, 0, 6'h00, 0, 32'hFC03, 32'h3100));
      // Cause is read-only; reg 15 reads PRID or 0
      vecs.push_back(mk(1, 13, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 6'h00, 0, 32'h0, 32'h3100));
      vecs.push_back(mk(1, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0, 32'h0, 32'h3100));
      vecs.push_back(mk(1, 15, 32'h123, 1, 0, 0, 0, 0, 6'h00, 0, EXP_PRID, 32'h3100));
      vecs.push_back(mk(1, 15, 0, 0, 0, 0, 0, 0, 6'h00, 0, EXP_PRID, 32'h3100));
      // eret, then interrupt and syscall together: interrupt wins
      vecs.push_back(mk(1, 12, 0, 0, 0, 0, 0, 1, 6'h00, 0, 32'hFC03, 32'h3100));
      vecs.push_back(mk(1, 13, 0, 0, 32'h3200, 0, 5'd8, 0, 6'h01, 1, 32'h0, 32'h3100));
      vecs.push_back(mk(1, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0, 32'h400, 32'h3200));
      vecs.push_back(mk(1, 12, 0, 0, 0, 0, 0, 0, 6'h00, 0, 32'hFC03, 32'h3200));

      // two reset cycles
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0));
      repeat (2) @(posedge clk);
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         #1;
         check32("req", i, {31'b0, bus.Req}, {31'b0, vecs[i].exp_req});
         check32("rdata", i, bus.M_CP0_Rdata, vecs[i].exp_rd);
         check32("epc_out", i, bus.EPC_out, vecs[i].exp_epc);
         @(posedge clk);
         @(negedge clk);
      end

      check32("handler_pc", 0, bus.Handler_PC, 32'h0000_4180);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
